// File: rtl/zxuno_cfg_regbank.sv
// ----------------------------------------------------------------------------
// zxuno_cfg_regbank
//
// Bank of NREGS 8-bit ZX-Uno configuration registers mapped at consecutive
// zxuno_addr slots BASEADDR..BASEADDR+NREGS-1. Each register has a per-bit
// write mask. An optional sticky lock bit (bit 7 of the last register)
// freezes selected registers. A Z80 I/O port snoop can flip one bit on the
// rising edge of a matching OUT. Any change to the register contents raises a
// one-cycle `changed` pulse and holds `settling` high for SETTLE cycles, so
// consumers can blank while a mode change takes effect.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   a            Z80 address bus
//   iorq_n       Z80 IORQ, active low
//   wr_n         Z80 WR, active low
//   zxuno_addr   selected ZX-Uno register address
//   zxuno_regrd  ZX-Uno register read strobe
//   zxuno_regwr  ZX-Uno register write (level, acts every cycle it is high)
//   din          write data (ZX-Uno write and snooped OUT data)
//   dout         registered read data, one cycle after the address
//   oe_n         combinational output enable, low on an in-range read
//   regs         live register contents, flat, register i = [8i+7:8i]
//   changed      registered one-cycle pulse when any register bit changed
//   settling     high for SETTLE cycles after the most recent change
// ----------------------------------------------------------------------------
module zxuno_cfg_regbank #(
    parameter logic [7:0]         BASEADDR   = 8'h0B,
    parameter int unsigned        NREGS      = 4,
    parameter logic [8*NREGS-1:0] RSTVAL     = '0,
    parameter logic [8*NREGS-1:0] WRMASK     = '1,
    parameter logic [NREGS-1:0]   LOCKMASK   = '1,
    parameter bit                 LOCK_EN    = 1'b1,
    parameter logic [15:0]        SNOOP_PORT = 16'h8E3B,
    parameter int unsigned        SNOOP_REG  = 0,
    parameter int unsigned        SNOOP_BIT  = 7,
    parameter int unsigned        SETTLE     = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        a,
    input  logic               iorq_n,
    input  logic               wr_n,
    input  logic [7:0]         zxuno_addr,
    input  logic               zxuno_regrd,
    input  logic               zxuno_regwr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               oe_n,
    output logic [8*NREGS-1:0] regs,
    output logic               changed,
    output logic               settling
);

    localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned CW = $clog2(SETTLE + 1);

    // Register storage
    logic [7:0]       regs_q [NREGS];
    logic [7:0]       regs_d [NREGS];

    // Address decode
    logic [7:0]       addr_off;
    logic [IW-1:0]    idx;
    logic             hit;

    // Write, lock and snoop qualification
    logic             lock_act;
    logic [NREGS-1:0] wr_sel;
    logic             sw;
    logic             sw_q;
    logic             snoop_edge;

    // Change detection and settle timer
    logic             any_change;
    logic [CW-1:0]    cnt_q;
    logic             changed_q;
    logic             settling_q;

    // Read path
    logic [7:0]       rd_data;
    logic [7:0]       dout_q;

    // ------------------------------------------------------------------------
    // Address decode: subtraction wraps, so the lower bound is checked apart.
    // ------------------------------------------------------------------------
    always_comb begin
        addr_off = zxuno_addr - BASEADDR;
        hit      = (zxuno_addr >= BASEADDR) && (32'(addr_off) < NREGS);
        idx      = addr_off[IW-1:0];
    end

    assign oe_n = ~(zxuno_regrd & hit);

    // ------------------------------------------------------------------------
    // Lock is bit 7 of the top register; it only ever reads back as 1 once set.
    // ------------------------------------------------------------------------
    assign lock_act = LOCK_EN && regs_q[NREGS-1][7];

    // Snooped Z80 OUT: only the 0->1 transition of the qualified strobe acts.
    assign sw         = ~iorq_n & ~wr_n & (a == SNOOP_PORT);
    assign snoop_edge = sw & ~sw_q;

    // ------------------------------------------------------------------------
    // Next-state for the register bank
    // ------------------------------------------------------------------------
    always_comb begin
        wr_sel     = '0;
        any_change = 1'b0;
        rd_data    = 8'h00;

        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            wr_sel[i] = zxuno_regwr && hit && (32'(idx) == i) &&
                        !(lock_act && LOCKMASK[i]);
            if (wr_sel[i]) begin
                regs_d[i] = (regs_q[i] & ~WRMASK[8*i +: 8]) | (din & WRMASK[8*i +: 8]);
            end
            if (hit && (32'(idx) == i)) begin
                rd_data = regs_q[i];
            end
        end

        // An accepted ZX-Uno write to the snooped register takes precedence;
        // a write blocked by the lock does not count as a write here.
        if (snoop_edge && !wr_sel[SNOOP_REG]) begin
            regs_d[SNOOP_REG][SNOOP_BIT] = |din[3:0];
        end

        // Keep the lock sticky even if the top register is not lock-masked
        // or the snoop targets the lock bit.
        if (lock_act) begin
            regs_d[NREGS-1][7] = 1'b1;
        end

        for (int unsigned i = 0; i < NREGS; i++) begin
            if (regs_d[i] != regs_q[i]) begin
                any_change = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= RSTVAL[8*i +: 8];
            end
            dout_q     <= 8'h00;
            changed_q  <= 1'b0;
            settling_q <= 1'b0;
            cnt_q      <= '0;
            // Start idle-high so a strobe already asserted out of reset is
            // not mistaken for a fresh edge.
            sw_q       <= 1'b1;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dout_q    <= rd_data;
            changed_q <= any_change;
            sw_q      <= sw;
            if (any_change) begin
                // Retrigger reloads rather than accumulates.
                cnt_q      <= CW'(SETTLE);
                settling_q <= 1'b1;
            end else if (cnt_q != '0) begin
                cnt_q      <= cnt_q - CW'(1);
                settling_q <= (cnt_q != CW'(1));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs[8*i +: 8] = regs_q[i];
        end
    end

    assign dout     = dout_q;
    assign changed  = changed_q;
    assign settling = settling_q;

endmodule

// File: tb/tb_zxuno_cfg_regbank.sv
// Directed bench for zxuno_cfg_regbank: four registers at 0x0B..0x0E,
// register 1 only writable in bits [4:0], lock in bit 7 of register 3.
module tb_zxuno_cfg_regbank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic        iorq_n;
    logic        wr_n;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe_n;
    logic [31:0] regs;
    logic        changed;
    logic        settling;

    int tests = 0;
    int fails = 0;
    int n;
    int pulses;

    zxuno_cfg_regbank #(
        .BASEADDR  (8'h0B),
        .NREGS     (4),
        .RSTVAL    (32'h0000_0180),
        .WRMASK    (32'hFFFF_1FFF),
        .LOCKMASK  (4'b1111),
        .LOCK_EN   (1'b1),
        .SNOOP_PORT(16'h8E3B),
        .SNOOP_REG (0),
        .SNOOP_BIT (7),
        .SETTLE    (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .iorq_n     (iorq_n),
        .wr_n       (wr_n),
        .zxuno_addr (zxuno_addr),
        .zxuno_regrd(zxuno_regrd),
        .zxuno_regwr(zxuno_regwr),
        .din        (din),
        .dout       (dout),
        .oe_n       (oe_n),
        .regs       (regs),
        .changed    (changed),
        .settling   (settling)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required $finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zx_write(input logic [7:0] addr, input logic [7:0] data);
        zxuno_addr  = addr;
        din         = data;
        zxuno_regwr = 1'b1;
        tick();
        zxuno_regwr = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        a           = 16'h0000;
        iorq_n      = 1'b1;
        wr_n        = 1'b1;
        zxuno_addr  = 8'h00;
        zxuno_regrd = 1'b0;
        zxuno_regwr = 1'b0;
        din         = 8'h00;

        // 1. Reset state
        tick();
        tick();
        check("rst_regs", regs, 32'h0000_0180);
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_oe_n", {31'h0, oe_n}, 32'h1);
        check("rst_settling", {31'h0, settling}, 32'h0);
        check("rst_changed", {31'h0, changed}, 32'h0);
        rst_n = 1'b1;
        tick();

        // 2. Masked write, change pulse, settle length
        zx_write(8'h0C, 8'hFF);
        check("wr_masked_reg1", {24'h0, regs[15:8]}, 32'h1F);
        check("wr_changed_hi", {31'h0, changed}, 32'h1);
        check("wr_settling_hi", {31'h0, settling}, 32'h1);
        n = 1;
        tick();
        check("wr_changed_1cyc", {31'h0, changed}, 32'h0);
        while (settling && n < 2000) begin
            n++;
            tick();
        end
        check("settle_len", n, 1024);
        zx_write(8'h0C, 8'hFF);
        check("same_data_no_change", {31'h0, changed}, 32'h0);

        // 3. Lock
        zx_write(8'h0B, 8'h00);
        check("reg0_clear", {24'h0, regs[7:0]}, 32'h00);
        zx_write(8'h0E, 8'h80);
        check("lock_set", {24'h0, regs[31:24]}, 32'h80);
        zx_write(8'h0B, 8'h55);
        check("locked_reg0", {24'h0, regs[7:0]}, 32'h00);
        zx_write(8'h0E, 8'h00);
        check("lock_sticky", {24'h0, regs[31:24]}, 32'h80);
        a      = 16'h8E3B;
        din    = 8'h03;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        tick();
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        check("snoop_ignores_lock", {24'h0, regs[7:0]}, 32'h80);
        tick();

        // 4. Held snoop acts once; a new din while held must not retrigger
        din    = 8'h00;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (changed) pulses++;
            if (k == 0) din = 8'h01;
        end
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        tick();
        if (changed) pulses++;
        check("snoop_hold_reg0", {24'h0, regs[7:0]}, 32'h00);
        check("snoop_hold_events", pulses, 1);

        // Reset clears lock, then write/snoop collision on register 0
        rst_n = 1'b0;
        #1;
        check("rst_async_regs", regs, 32'h0000_0180);
        tick();
        rst_n = 1'b1;
        tick();
        zxuno_addr  = 8'h0B;
        din         = 8'h01;
        zxuno_regwr = 1'b1;
        a           = 16'h8E3B;
        iorq_n      = 1'b0;
        wr_n        = 1'b0;
        tick();
        zxuno_regwr = 1'b0;
        iorq_n      = 1'b1;
        wr_n        = 1'b1;
        check("collision_write_wins", {24'h0, regs[7:0]}, 32'h01);

        // 5. Reads
        zx_write(8'h0D, 8'h5A);
        zxuno_addr  = 8'h0D;
        zxuno_regrd = 1'b1;
        #1;
        check("rd_oe_n_in", {31'h0, oe_n}, 32'h0);
        tick();
        check("rd_reg2", {24'h0, dout}, 32'h5A);
        zxuno_addr = 8'h0F;
        #1;
        check("rd_oe_n_out", {31'h0, oe_n}, 32'h1);
        tick();
        check("rd_out_range", {24'h0, dout}, 32'h00);
        zxuno_addr  = 8'h0D;
        din         = 8'hA5;
        zxuno_regwr = 1'b1;
        tick();
        zxuno_regwr = 1'b0;
        check("rd_during_wr_old", {24'h0, dout}, 32'h5A);
        check("rd_during_wr_reg", {24'h0, regs[23:16]}, 32'hA5);
        tick();
        check("rd_after_wr_new", {24'h0, dout}, 32'hA5);
        zxuno_addr  = 8'h0A;
        din         = 8'hFF;
        zxuno_regwr = 1'b1;
        #1;
        check("below_base_oe_n", {31'h0, oe_n}, 32'h1);
        tick();
        zxuno_regwr = 1'b0;
        zxuno_regrd = 1'b0;
        check("below_base_no_write", regs, 32'h00A5_0101);

        // 6. Settle retrigger and reset mid-count
        zx_write(8'h0C, 8'h1E);
        check("retrig_reg1_a", {24'h0, regs[15:8]}, 32'h1E);
        repeat (499) tick();
        zx_write(8'h0C, 8'h03);
        check("retrig_reg1_b", {24'h0, regs[15:8]}, 32'h03);
        repeat (1023) tick();
        check("retrig_hi_t1523", {31'h0, settling}, 32'h1);
        tick();
        check("retrig_lo_t1524", {31'h0, settling}, 32'h0);
        zx_write(8'h0C, 8'h07);
        repeat (100) tick();
        check("midcount_hi", {31'h0, settling}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midcount_rst_settling", {31'h0, settling}, 32'h0);
        check("midcount_rst_changed", {31'h0, changed}, 32'h0);
        check("midcount_rst_dout", {24'h0, dout}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_no_change", {31'h0, changed}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
